shift_req_stage: RTL and testbench
==================================

// Module: shift_req_stage
// PURPOSE
// - Pipeline stage directly upstream of the 16-bit barrel shifter in execute.
// - Captures shift requests from decode, resolves the shift count, and buffers in a 2-entry skid.
// - Presents In/Cnt/Op-ready operands to the shifter under a valid/ready handshake.
// - Sustains 1 req/cycle with no bubbles, and decouples decode from execute backpressure.
// PARAMETERS
// - DATA_W  16  operand width
// - CNT_W    4  shift-count width (log2 DATA_W)
// - DST_W    3  destination register index width
// PORTS
// - clk            in   1      clock, rising edge
// - rst_n          in   1      reset, asynchronous, active-low
// - flush          in   1      drop all buffered requests (branch/exception squash)
// - in_valid       in   1      decode presents a request
// - in_ready       out  1      stage can accept a request
// - in_data        in   16     value to be shifted
// - in_op          in   2      00 rotate-left, 01 shift-left, 10 rotate-right, 11 shift-right-logical
// - in_cnt_src     in   1      0 = use in_imm, 1 = use in_reg[3:0]
// - in_imm         in   4      immediate count
// - in_reg         in   16     register-sourced count operand
// - in_dst         in   3      destination register tag, passed through
// - out_valid      out  1      request presented to shifter
// - out_ready      in   1      shifter/execute consumes request
// - out_data       out  16     to shifter In
// - out_cnt        out  4      to shifter Cnt
// - out_op         out  2      to shifter Op
// - out_dst        out  3      destination tag
// - out_nop        out  1      out_cnt == 0; result equals out_data
// - perf_stall_cnt out  16     stall counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset: out_valid=0, in_ready=1, out_data/out_cnt/out_op/out_dst=0, out_nop=1, skid cleared, perf_stall_cnt=0.
// - Handshakes:
//   - accept = in_valid & in_ready; drain = out_valid & out_ready.
//   - in_ready is registered and equals !skid_valid; no combinational path from out_ready.
// - Count: resolved at capture as in_cnt_src ? in_reg[3:0] : in_imm. Upper in_reg bits are ignored.
// - States (main_valid, skid_valid):
//   - EMPTY: accept -> ONE, request loaded into main.
//   - ONE, accept & !drain -> FULL: request loaded into skid.
//   - ONE, accept & drain -> ONE: main reloaded with new request.
//   - ONE, !accept & drain -> EMPTY.
//   - FULL: in_ready=0. drain -> ONE, skid moves to main.
// - Latency: 1 cycle from accept to out_valid when EMPTY. Strict FIFO order.
// - Stability: while out_valid & !out_ready, all out_* are held stable.
// - flush:
//   - Highest priority. Next state is EMPTY; a same-cycle accept is discarded.
//   - in_ready=1 the following cycle. Drain in the flush cycle is still a valid transfer.
// - Reset mid-operation: rst_n low clears state immediately, independent of clk.
// CONFIGURATION
// - SHIFT_REQ_PERF_EN defined:
//   - perf_stall_cnt increments each cycle with out_valid & !out_ready.
//   - Saturates at 16'hFFFF. Reset clears it; flush does not.
// - Undefined: perf_stall_cnt tied to 0 and no counter logic is built.
// STRUCTURE
// - shift_pkg:
//   - typedef shift_op_t with ROL/SLL/ROR/SRL encodings.
//   - shift_req_t struct {data, cnt, op, dst}.
//   - Constants SHIFT_DATA_W and SHIFT_CNT_W.
// - Sub-module shift_skid_slot: one registered shift_req_t and its valid bit, with load/clear.
//   - Instanced twice, as main and skid.
// - The FSM is implied by the (main_valid, skid_valid) pair; no separate state register.
// TESTING
// - Single req: in_data=16'h8001, op=00, imm=1, out_ready=1.
//   -> next cycle out_valid=1, out_cnt=1, out_nop=0; shifter yields 16'h0003.
// - Reg count: in_cnt_src=1, in_reg=16'hFFF5 -> out_cnt=4'h5, upper bits ignored.
// - Backpressure: out_ready=0, issue A,B,C back-to-back.
//   -> A held, B in skid, in_ready=0, C held by decode.
//   -> Raise out_ready: A,B,C delivered in order with no bubbles.
// - Streaming: 8 reqs with out_ready=1 -> 8 transfers in 8 consecutive cycles.
// - Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped req never appears.
// - Async reset asserted mid-stream between edges -> out_valid=0 immediately.
//   -> With SHIFT_REQ_PERF_EN: 5 stall cycles read back as perf_stall_cnt=5, then 0 after reset.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types, widths and count resolution for the shift request stage
package shift_pkg;

   localparam int SHIFT_DATA_W = 16;
   localparam int SHIFT_CNT_W  = 4;
   localparam int SHIFT_DST_W  = 3;

   typedef enum logic [1:0] {
      OP_ROL = 2'b00,
      OP_SLL = 2'b01,
      OP_ROR = 2'b10,
      OP_SRL = 2'b11
   } shift_op_t;

   typedef struct packed {
      logic [SHIFT_DATA_W-1:0] data;
      logic [SHIFT_CNT_W-1:0]  cnt;
      shift_op_t               op;
      logic [SHIFT_DST_W-1:0]  dst;
   } shift_req_t;

   // Register-sourced counts only use the low bits; a 16-bit shifter never needs more.
   function automatic logic [SHIFT_CNT_W-1:0] resolve_cnt(
      input logic                    src,
      input logic [SHIFT_CNT_W-1:0]  imm,
      input logic [SHIFT_DATA_W-1:0] rg
   );
      return src ? rg[SHIFT_CNT_W-1:0] : imm;
   endfunction

endpackage

// File: rtl/shift_skid_slot.sv
// rtl/shift_skid_slot.sv - one buffered shift request with its valid bit
module shift_skid_slot
   import shift_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       clear,
   input  shift_req_t d,
   output logic       valid,
   output shift_req_t q
);

   // Load wins over clear; clearing only drops valid so held payload bits do not toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_req_stage.sv
// rtl/shift_req_stage.sv - shift request capture and 2-entry skid ahead of the barrel shifter; SHIFT_REQ_PERF_EN builds the stall counter
module shift_req_stage
   import shift_pkg::*;
#(
   parameter int DATA_W = SHIFT_DATA_W,
   parameter int CNT_W  = SHIFT_CNT_W,
   parameter int DST_W  = SHIFT_DST_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_op,
   input  logic              in_cnt_src,
   input  logic [CNT_W-1:0]  in_imm,
   input  logic [DATA_W-1:0] in_reg,
   input  logic [DST_W-1:0]  in_dst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_cnt,
   output logic [1:0]        out_op,
   output logic [DST_W-1:0]  out_dst,
   output logic              out_nop,
   output logic [15:0]       perf_stall_cnt
);

   logic       accept;
   logic       drain;
   shift_req_t new_req;
   logic       main_valid, skid_valid;
   shift_req_t main_q, skid_q, main_d;
   logic       main_load, main_clear, skid_load, skid_clear;

   assign accept  = in_valid & in_ready;
   assign drain   = out_valid & out_ready;
   assign new_req = '{data: in_data,
                      cnt:  resolve_cnt(in_cnt_src, in_imm, in_reg),
                      op:   shift_op_t'(in_op),
                      dst:  in_dst};

   // Slot control: the (main_valid, skid_valid) pair is the state; flush overrides everything.
   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_d     = new_req;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (skid_valid) begin
         if (drain) begin
            main_load  = 1'b1;
            main_d     = skid_q;
            skid_clear = 1'b1;
         end
      end else if (main_valid) begin
         if (accept && drain) begin
            main_load = 1'b1;
         end else if (accept) begin
            skid_load = 1'b1;
         end else if (drain) begin
            main_clear = 1'b1;
         end
      end else if (accept) begin
         main_load = 1'b1;
      end
   end

   shift_skid_slot u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .valid (main_valid),
      .q     (main_q)
   );

   shift_skid_slot u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (new_req),
      .valid (skid_valid),
      .q     (skid_q)
   );

   // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_q.data;
   assign out_cnt   = main_q.cnt;
   assign out_op    = main_q.op;
   assign out_dst   = main_q.dst;
   assign out_nop   = (main_q.cnt == '0);

`ifdef SHIFT_REQ_PERF_EN
   logic [15:0] stall_q;

   // Count cycles the shifter holds off a presented request; saturates, survives flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign perf_stall_cnt = stall_q;
`else
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_shift_req_stage.sv
// tb/tb_shift_req_stage.sv - self-checking bench for shift_req_stage
module tb_shift_req_stage;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, in_cnt_src;
   logic [15:0] in_data, in_reg;
   logic [1:0]  in_op;
   logic [3:0]  in_imm;
   logic [2:0]  in_dst;
   logic        out_valid, out_ready, out_nop;
   logic [15:0] out_data, perf_stall_cnt;
   logic [3:0]  out_cnt;
   logic [1:0]  out_op;
   logic [2:0]  out_dst;

   always #5 clk = ~clk;

   shift_req_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_op          (in_op),
      .in_cnt_src     (in_cnt_src),
      .in_imm         (in_imm),
      .in_reg         (in_reg),
      .in_dst         (in_dst),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_cnt        (out_cnt),
      .out_op         (out_op),
      .out_dst        (out_dst),
      .out_nop        (out_nop),
      .perf_stall_cnt (perf_stall_cnt)
   );

   typedef struct {
      logic [15:0] data;
      logic [3:0]  cnt;
      logic [1:0]  op;
      logic [2:0]  dst;
      logic [15:0] res;
   } exp_t;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  op;
      logic        src;
      logic [3:0]  imm;
      logic [15:0] rg;
      logic [2:0]  dst;
      logic [3:0]  exp_cnt;
      logic [15:0] exp_res;
   } vec_t;

   exp_t        sbq[$];
   exp_t        cur_exp;
   exp_t        e;
   vec_t        vecs[8];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          n_drain = 0;
   int          first_drain = -1;
   int          last_drain = -1;
   logic [15:0] perf_model = '0;
   logic        hold_prev = 1'b0;
   logic [15:0] p_data;
   logic [3:0]  p_cnt;
   logic [1:0]  p_op;
   logic [2:0]  p_dst;

   // Reference barrel shifter.
   function automatic logic [15:0] shf(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
      logic [31:0] t;
      t = '0;
      case (op)
         2'b00: begin t = {d, d} << c; return t[31:16]; end
         2'b01: return d << c;
         2'b10: begin t = {d, d} >> c; return t[15:0]; end
         default: return d >> c;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: sample at negedge, pop on drain, push on accept.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         sbq.delete();
         perf_model = '0;
         hold_prev  = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(p_data));
            chk("hold_cnt", 32'(out_cnt), 32'(p_cnt));
            chk("hold_op", 32'(out_op), 32'(p_op));
            chk("hold_dst", 32'(out_dst), 32'(p_dst));
         end
`ifdef SHIFT_REQ_PERF_EN
         chk("perf_track", 32'(perf_stall_cnt), 32'(perf_model));
`else
         chk("perf_tied", 32'(perf_stall_cnt), 32'd0);
`endif
         if (out_valid && out_ready) begin
            n_drain++;
            if (first_drain < 0) first_drain = cyc;
            last_drain = cyc;
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got data %0h, expected no output", out_data);
            end else begin
               e = sbq.pop_front();
               chk("sb_data", 32'(out_data), 32'(e.data));
               chk("sb_cnt", 32'(out_cnt), 32'(e.cnt));
               chk("sb_op", 32'(out_op), 32'(e.op));
               chk("sb_dst", 32'(out_dst), 32'(e.dst));
               chk("sb_nop", 32'(out_nop), 32'(e.cnt == 4'd0));
               chk("sb_result", 32'(shf(out_data, out_cnt, out_op)), 32'(e.res));
            end
         end
         if (flush) sbq.delete();
         else if (in_valid && in_ready) sbq.push_back(cur_exp);
         hold_prev = out_valid && !out_ready && !flush;
         p_data = out_data;
         p_cnt  = out_cnt;
         p_op   = out_op;
         p_dst  = out_dst;
`ifdef SHIFT_REQ_PERF_EN
         if (out_valid && !out_ready && perf_model != 16'hFFFF) perf_model++;
`endif
      end
   end

   task automatic send(input logic [15:0] d, input logic [1:0] op, input logic src, input logic [3:0] imm,
                       input logic [15:0] rg, input logic [2:0] dst, input logic [3:0] ecnt, input logic [15:0] eres);
      logic ok;
      ok = 1'b0;
      in_data = d; in_op = op; in_cnt_src = src; in_imm = imm; in_reg = rg; in_dst = dst;
      cur_exp = '{d, ecnt, op, dst, eres};
      in_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: got in_ready 0, expected 1 within 40 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [15:0] d, input logic [1:0] op, input logic src, input logic [3:0] imm,
                         input logic [15:0] rg, input logic [2:0] dst);
      logic [3:0] c;
      c = src ? rg[3:0] : imm;
      send(d, op, src, imm, rg, dst, c, shf(d, c, op));
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (!out_valid && sbq.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_timeout: got %0d pending, expected 0", sbq.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish by 200000");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{16'h8001, 2'd0, 1'b0, 4'd1,  16'h0000, 3'd1, 4'd1,  16'h0003};
      vecs[1] = '{16'h00FF, 2'd1, 1'b1, 4'd0,  16'hFFF5, 3'd2, 4'd5,  16'h1FE0};
      vecs[2] = '{16'h0001, 2'd2, 1'b0, 4'd4,  16'h0000, 3'd3, 4'd4,  16'h1000};
      vecs[3] = '{16'hF000, 2'd3, 1'b0, 4'd12, 16'h0000, 3'd4, 4'd12, 16'h000F};
      vecs[4] = '{16'h1234, 2'd0, 1'b0, 4'd0,  16'h0000, 3'd5, 4'd0,  16'h1234};
      vecs[5] = '{16'hABCD, 2'd1, 1'b1, 4'd7,  16'h0010, 3'd6, 4'd0,  16'hABCD};
      vecs[6] = '{16'h8000, 2'd0, 1'b0, 4'd15, 16'h0000, 3'd7, 4'd15, 16'h4000};
      vecs[7] = '{16'hFFFF, 2'd1, 1'b0, 4'd15, 16'h0000, 3'd0, 4'd15, 16'h8000};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0;
      in_cnt_src = 1'b0; in_imm = '0; in_reg = '0; in_dst = '0; out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_cnt", 32'(out_cnt), 32'd0);
      chk("rst_out_op", 32'(out_op), 32'd0);
      chk("rst_out_dst", 32'(out_dst), 32'd0);
      chk("rst_out_nop", 32'(out_nop), 32'd1);
      chk("rst_perf", 32'(perf_stall_cnt), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Single request: one-cycle latency
      send(16'h8001, 2'd0, 1'b0, 4'd1, 16'h0000, 3'd1, 4'd1, 16'h0003);
      @(negedge clk);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_cnt", 32'(out_cnt), 32'd1);
      chk("single_nop", 32'(out_nop), 32'd0);
      chk("single_result", 32'(shf(out_data, out_cnt, out_op)), 32'h0003);
      wait_idle();

      // Register-sourced count ignores upper bits
      send(16'h1234, 2'd1, 1'b1, 4'd0, 16'hFFF5, 3'd2, 4'd5, 16'h4680);
      @(negedge clk);
      chk("regcnt_cnt", 32'(out_cnt), 32'h5);
      wait_idle();

      // Streaming table: 8 back-to-back requests
      first_drain = -1; n_drain = 0;
      for (int i = 0; i < 8; i++)
         send(vecs[i].data, vecs[i].op, vecs[i].src, vecs[i].imm, vecs[i].rg, vecs[i].dst,
              vecs[i].exp_cnt, vecs[i].exp_res);
      wait_idle();
      chk("stream_count", 32'(n_drain), 32'd8);
      chk("stream_span", 32'(last_drain - first_drain), 32'd7);

      // Backpressure: A held, B in skid, C held by decode
      out_ready = 1'b0;
      send_m(16'hAAAA, 2'd0, 1'b0, 4'd2, 16'h0000, 3'd5);
      send_m(16'hBBBB, 2'd3, 1'b1, 4'd0, 16'h0023, 3'd6);
      in_data = 16'hCCCC; in_op = 2'd2; in_cnt_src = 1'b0; in_imm = 4'd8; in_reg = '0; in_dst = 3'd7;
      cur_exp = '{16'hCCCC, 4'd8, 2'd2, 3'd7, shf(16'hCCCC, 4'd8, 2'd2)};
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_head", 32'(out_data), 32'hAAAA);
      end
      @(posedge clk); #1;
      first_drain = -1; n_drain = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_idle();
      chk("bp_count", 32'(n_drain), 32'd3);
      chk("bp_span", 32'(last_drain - first_drain), 32'd2);

      // Flush while FULL with a request on the input
      out_ready = 1'b0;
      send_m(16'h1111, 2'd1, 1'b0, 4'd1, 16'h0000, 3'd1);
      send_m(16'h2222, 2'd1, 1'b0, 4'd2, 16'h0000, 3'd2);
      in_data = 16'hDEAD; in_op = 2'd0; in_imm = 4'd3; in_dst = 3'd3;
      cur_exp = '{16'hDEAD, 4'd3, 2'd0, 3'd3, shf(16'hDEAD, 4'd3, 2'd0)};
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_full_valid", 32'(out_valid), 32'd0);
      chk("flush_full_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Flush in ONE with same-cycle drain (kept) and accept (discarded)
      out_ready = 1'b1;
      send_m(16'h3333, 2'd3, 1'b0, 4'd4, 16'h0000, 3'd4);
      in_data = 16'hBEEF; in_op = 2'd1; in_imm = 4'd1; in_dst = 3'd5;
      cur_exp = '{16'hBEEF, 4'd1, 2'd1, 3'd5, shf(16'hBEEF, 4'd1, 2'd1)};
      first_drain = -1; n_drain = 0;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_one_valid", 32'(out_valid), 32'd0);
      chk("flush_one_ready", 32'(in_ready), 32'd1);
      chk("flush_one_drain", 32'(n_drain), 32'd1);
      @(posedge clk); #1;
      send_m(16'h4444, 2'd2, 1'b1, 4'd0, 16'h00F3, 3'd6);
      wait_idle();

      // Stall counter then asynchronous reset mid-cycle
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b0;
      send_m(16'h5555, 2'd0, 1'b0, 4'd5, 16'h0000, 3'd2);
      repeat (5) @(negedge clk);
      @(negedge clk);
`ifdef SHIFT_REQ_PERF_EN
      chk("perf_five", 32'(perf_stall_cnt), 32'd5);
`else
      chk("perf_five_tied", 32'(perf_stall_cnt), 32'd0);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_valid", 32'(out_valid), 32'd0);
      chk("areset_ready", 32'(in_ready), 32'd1);
      chk("areset_perf", 32'(perf_stall_cnt), 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_reset_valid", 32'(out_valid), 32'd0);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
